// File: rtl/vsync_pi_filter_pkg.sv
// Shared definitions for the Vsync phase detector / PI loop filter:
// FSM state encoding, default widths and the saturating clamp helper.
package vsync_pi_filter_pkg;

  localparam int DEF_WIDTH     = 17;
  localparam int DEF_WIDTH_ERR = 22;

  typedef enum logic [2:0] {
    S_WAIT_REF,
    S_TRACK,
    S_ERR,
    S_INT,
    S_OUT
  } state_e;

  // Wide enough that no PI sum or shift can wrap before clamping.
  typedef logic signed [63:0] wide_t;

  function automatic wide_t sat(input wide_t v, input wide_t lo, input wide_t hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

endpackage

// File: rtl/vsync_phase_meter.sv
// Vsync synchroniser, Vsync/fref rising-edge detectors and the phase counter
// measuring cycles since the last fref rise.
module vsync_phase_meter
  import vsync_pi_filter_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             vsync_i,
  input  logic             fref_i,
  output logic [WIDTH-1:0] pc_o,
  output logic             cap_o,
  output logic             fref_rise_o
);

  logic             vs_s1_q, vs_s2_q, vs_d_q;
  logic             fref_q;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             vs_rise, fref_rise;

  assign vs_rise   = vs_s2_q & ~vs_d_q;
  assign fref_rise = fref_i & ~fref_q;

  always_comb begin
    cnt_d = cnt_q;
    if (fref_rise) begin
      cnt_d = '0;
    end else if (cnt_q != '1) begin
      cnt_d = cnt_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vs_s1_q <= 1'b0;
      vs_s2_q <= 1'b0;
      vs_d_q  <= 1'b0;
      fref_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      vs_s1_q <= vsync_i;
      vs_s2_q <= vs_s1_q;
      vs_d_q  <= vs_s2_q;
      fref_q  <= fref_i;
      cnt_q   <= cnt_d;
    end
  end

  // The next counter value is presented so a coincident fref rise reads as 0
  // and the consumer can latch the capture on the same edge as vs_rise.
  assign pc_o        = cnt_d;
  assign cap_o       = vs_rise;
  assign fref_rise_o = fref_rise;

endmodule

// File: rtl/vsync_pi_filter.sv
// Phase detector and PI loop filter driving the signed fractional correction mf.
// Optional build macro VSYNC_PI_WINDOW_GATE_EN: window-gated integrator and clamped P term.
module vsync_pi_filter
  import vsync_pi_filter_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int WIDTH_ERR = DEF_WIDTH_ERR,
  parameter int LOCK_CNT  = 8
) (
  input  logic                        sys_clk,
  input  logic                        sync_rst_n,
  input  logic                        vsync_in,
  input  logic                        fref,
  input  logic [WIDTH-1:0]            m0,
  input  logic [2:0]                  ki,
  input  logic [2:0]                  kp,
  input  logic [2:0]                  k0,
  input  logic [WIDTH_ERR-1:0]        dlim,
  input  logic [9:0]                  win_width,
  output logic signed [WIDTH-1:0]     mf,
  output logic signed [WIDTH_ERR-1:0] err,
  output logic                        sample,
  output logic                        Venable,
  output logic                        pd_error
);

  localparam int    LW     = $clog2(LOCK_CNT + 1);
  localparam wide_t MF_MAX = (wide_t'(1) <<< (WIDTH - 1)) - wide_t'(1);
  localparam wide_t MF_MIN = -(wide_t'(1) <<< (WIDTH - 1));

  logic [WIDTH-1:0] pc;
  logic             cap, fref_rise;

  vsync_phase_meter #(.WIDTH(WIDTH)) u_meter (
    .clk_i      (sys_clk),
    .rst_ni     (sync_rst_n),
    .vsync_i    (vsync_in),
    .fref_i     (fref),
    .pc_o       (pc),
    .cap_o      (cap),
    .fref_rise_o(fref_rise)
  );

  state_e                      state_q;
  logic signed [WIDTH_ERR-1:0] err_q, err_d;
  logic signed [WIDTH_ERR-1:0] integ_q, integ_d;
  logic signed [WIDTH-1:0]     mf_q, mf_d;
  logic [LW-1:0]               lock_q;
  logic                        sample_q, ven_q, pd_q;

  logic [WIDTH_ERR-1:0] pc_ext, m0_ext;
  wide_t                err_w, err_abs, lim, p_err, u;
  logic                 in_win, integ_en;

  always_comb begin
    pc_ext  = WIDTH_ERR'(pc);
    m0_ext  = WIDTH_ERR'(m0);
    err_d   = (pc < (m0 >> 1)) ? signed'(pc_ext) : signed'(pc_ext - m0_ext);
    err_w   = wide_t'(err_q);
    err_abs = (err_w < 0) ? -err_w : err_w;
    in_win  = (err_abs <= wide_t'(win_width));
    lim     = wide_t'(dlim);
    integ_d = WIDTH_ERR'(sat(wide_t'(integ_q) + wide_t'(err_q >>> ki), -lim, lim));
`ifdef VSYNC_PI_WINDOW_GATE_EN
    integ_en = in_win;
    p_err    = sat(err_w, -wide_t'(win_width), wide_t'(win_width));
`else
    integ_en = 1'b1;
    p_err    = err_w;
`endif
    u    = wide_t'(integ_q) + (p_err >>> kp);
    mf_d = WIDTH'(sat(u >>> k0, MF_MIN, MF_MAX));
  end

  // Each result register loads on the edge leaving the state that computes it,
  // so err, integ and mf/sample land at V+1, V+2 and V+3 respectively.
  always_ff @(posedge sys_clk or negedge sync_rst_n) begin
    if (!sync_rst_n) begin
      state_q  <= S_WAIT_REF;
      err_q    <= '0;
      integ_q  <= '0;
      mf_q     <= '0;
      lock_q   <= '0;
      sample_q <= 1'b0;
      ven_q    <= 1'b0;
      pd_q     <= 1'b0;
    end else begin
      sample_q <= 1'b0;
      if (cap) begin
        pd_q <= 1'b1;
      end else if (fref_rise) begin
        pd_q <= 1'b0;
      end
      unique case (state_q)
        S_WAIT_REF: begin
          if (fref_rise) state_q <= S_TRACK;
        end
        S_TRACK: begin
          if (cap && (m0 != '0)) begin
            err_q   <= err_d;
            state_q <= S_ERR;
          end
        end
        S_ERR: begin
          if (integ_en) integ_q <= integ_d;
          state_q <= S_INT;
        end
        S_INT: begin
          mf_q     <= mf_d;
          sample_q <= 1'b1;
          if (in_win) begin
            if (lock_q >= LW'(LOCK_CNT - 1)) begin
              lock_q <= LW'(LOCK_CNT);
              ven_q  <= 1'b1;
            end else begin
              lock_q <= lock_q + LW'(1);
            end
          end else begin
            lock_q <= '0;
            ven_q  <= 1'b0;
          end
          state_q <= S_OUT;
        end
        S_OUT: begin
          state_q <= S_TRACK;
        end
        default: begin
          state_q <= S_WAIT_REF;
        end
      endcase
    end
  end

  assign mf       = mf_q;
  assign err      = err_q;
  assign sample   = sample_q;
  assign Venable  = ven_q;
  assign pd_error = pd_q;

endmodule

// File: doc/vsync_pi_filter.md
# vsync_pi_filter

Phase detector and proportional-integral loop filter for the Vsync-locked fractional divider. It measures the phase of the incoming Vsync edge against the divider output `Fref`, applies a windowed and saturated PI law, and drives the signed fractional correction `mf` back into `frac_divider`. It also produces the `sample`, `Venable` and `pd_error` debug/status signals routed to D1, D2 and TP6.

## Interface
- `WIDTH`, 17: width of `m0` and `mf`.
- `WIDTH_ERR`, 22: signed width of phase error, integrator and `dlim`.
- `LOCK_CNT`, 8: consecutive in-window samples required to assert `Venable`.
- `sys_clk`  in  1: system clock (sp_clk, 50 MHz).
- `sync_rst_n`  in  1: reset, asynchronous assert, active-low.
- `vsync_in`  in  1: Vsync, asynchronous to `sys_clk`.
- `fref`  in  1: `frac_divider` q_out, synchronous to `sys_clk`.
- `m0`  in  WIDTH: nominal divide count, unsigned.
- `ki`, `kp`, `k0`  in  3 each: right-shift gains.
- `dlim`  in  WIDTH_ERR: positive integrator limit.
- `win_width`  in  10: lock window half-width, cycles.
- `mf`  out  WIDTH: signed fractional correction to `frac_divider`.
- `err`  out  WIDTH_ERR: last signed phase error.
- `sample`  out  1: one-cycle pulse on each `mf` update.
- `Venable`  out  1: lock indicator.
- `pd_error`  out  1: high from Vsync edge to next `fref` rise.

## Operation
- Reset: all outputs and state are 0, with FSM in `S_WAIT_REF`.
- `vsync_in`: 2-FF synchroniser followed by a rising-edge detector, producing `vs_rise`. `fref`: 1-FF edge detector, producing `fref_rise`.
- Phase counter: cleared on `fref_rise`, otherwise increments and saturates at all-ones.
- FSM:
  - `S_WAIT_REF`: waits for the first `fref_rise`, then goes to `S_TRACK`. Vsync edges in this state are ignored.
  - `S_TRACK`: on `vs_rise`, captures `pc` = phase counter value (0 if `fref_rise` occurs in the same cycle), then goes to `S_ERR`.
  - `S_ERR`: computes `err = (pc < m0>>1) ? pc : pc - m0`, sign-extended to WIDTH_ERR.
  - `S_INT`: `integ <= clamp(integ + (err >>> ki), -dlim, +dlim)`.
  - `S_OUT`: `u = integ + (err >>> kp)`; `mf <= clamp(u >>> k0)` to the signed WIDTH range; pulses `sample`; returns to `S_TRACK`.
- `vs_rise` while in `S_ERR`, `S_INT` or `S_OUT` is dropped.
- `m0 == 0`: captures are ignored, `mf` and `integ` hold.
- All shifts are arithmetic. Intermediate sums use WIDTH_ERR+1 bits before clamping, so no wrap-around is possible.
- Lock: `|err| <= win_width` counts as in-window. `Venable` asserts at the `S_OUT` of the LOCK_CNT-th consecutive in-window sample. Any out-of-window sample clears both the counter and `Venable` at that `S_OUT`.
- `pd_error`: set on `vs_rise`, cleared on `fref_rise`; set wins if both occur in the same cycle.
- Deasserting `sync_rst_n` mid-calculation returns the block to the reset state immediately.

## Timing
- `vsync_in` to `vs_rise`: 2–3 cycles (synchroniser).
- With `vs_rise` in cycle V: `err` valid at V+1, `integ` at V+2, `mf`/`sample`/`Venable` at V+3.
- `mf` holds between updates and changes only in cycles where `sample`=1.
- Minimum Vsync spacing for every edge to be processed: 4 cycles.

## Configuration
- `VSYNC_PI_WINDOW_GATE_EN` defined:
  - Out-of-window samples do not update `integ`.
  - The P term uses `err` clamped to ±`win_width`.
- Not defined: every sample updates `integ`, and the P term uses the raw `err`.
- Lock detection is identical in both builds.

## Structure
- Shared package / defines header holds:
  - FSM state encodings (`S_WAIT_REF`, `S_TRACK`, `S_ERR`, `S_INT`, `S_OUT`).
  - Default WIDTH/WIDTH_ERR.
  - Clamp helper function.
- One sub-module, `vsync_phase_meter`: synchroniser, both edge detectors, phase counter and `pc` capture. It outputs `pc` plus a capture-valid pulse.
- FSM, PI arithmetic and lock logic stay in the top-level module.

## Test plan
All cases use `m0`=100, with `fref` rising every 100 cycles; phase is measured at `vs_rise`.
- `pc`=10, `ki`=1, `kp`=1, `k0`=0, `dlim`=1000 -> `err`=+10, `integ`=5, `mf`=10, `sample` at V+3.
- `pc`=90, same gains -> `err`=−10, `mf`=−10; a second identical sample gives `mf`=−15.
- `pc`=40, `ki`=0, `kp`=7, `dlim`=100 -> successive `integ` 40, 80, 100, 100 (clamped).
- `win_width`=16, eight samples at `pc`=5 -> `Venable`=1 at the 8th `S_OUT`; then `pc`=30 -> `Venable`=0 at that `S_OUT`. With the gate macro defined, `integ` is unchanged by the `pc`=30 sample.
- `vs_rise` coincident with `fref_rise` -> `err`=0 and `pd_error`=1. A second `vs_rise` 2 cycles later is ignored.
- `sync_rst_n` low during `S_INT` -> `mf`, `err`, `sample`, `Venable`, `pd_error` = 0 in the same cycle. After release, no update occurs until the first `fref_rise` has been seen.
